// File: rtl/dmem_arb_pkg.sv
// ============================================================================
// Module  : dmem_arb_pkg
// Brief   : Shared state encoding and default widths for the dmem arbiter.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

package dmem_arb_pkg;

  localparam int C_ADDR_W_DFLT = 4;
  localparam int C_DATA_W_DFLT = 8;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    GNT_CPU = 2'd1,
    GNT_DBG = 2'd2
  } arb_state_e;

endpackage : dmem_arb_pkg

`default_nettype wire

// File: rtl/dmem_arb_pick.sv
// ============================================================================
// Module  : dmem_arb_pick
// Brief   : Combinational winner selection between CPU and DBG requesters.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module dmem_arb_pick (
  input  logic cpu_req_i,
  input  logic dbg_req_i,
  input  logic prio_dbg_i,
  output logic win_cpu_o,
  output logic win_dbg_o
);

  // prio_dbg_i only matters on contention; history policy lives in the parent.
  always_comb begin
    win_cpu_o = 1'b0;
    win_dbg_o = 1'b0;
    unique case ({cpu_req_i, dbg_req_i})
      2'b10:   win_cpu_o = 1'b1;
      2'b01:   win_dbg_o = 1'b1;
      2'b11: begin
        win_cpu_o = ~prio_dbg_i;
        win_dbg_o = prio_dbg_i;
      end
      default: begin
        win_cpu_o = 1'b0;
        win_dbg_o = 1'b0;
      end
    endcase
  end

endmodule : dmem_arb_pick

`default_nettype wire

// File: rtl/dmem_arbiter.sv
// ============================================================================
// Module  : dmem_arbiter
// Brief   : Two-port (CPU / debug) data-memory arbiter with registered grants.
//           Define DMEM_ARB_ROUND_ROBIN_EN for round-robin arbitration instead
//           of fixed CPU priority with a DBG starvation guard.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module dmem_arbiter
  import dmem_arb_pkg::*;
#(
  parameter int ADDR_W     = C_ADDR_W_DFLT,
  parameter int DATA_W     = C_DATA_W_DFLT,
  parameter int STARVE_MAX = 7
) (
  input  logic              clk_i,
  input  logic              rst_ni,

  input  logic              cpu_req_i,
  input  logic              cpu_we_i,
  input  logic [ADDR_W-1:0] cpu_addr_i,
  input  logic [DATA_W-1:0] cpu_wdata_i,
  output logic              cpu_gnt_o,
  output logic              cpu_rvalid_o,
  output logic [DATA_W-1:0] cpu_rdata_o,

  input  logic              dbg_req_i,
  input  logic              dbg_we_i,
  input  logic [ADDR_W-1:0] dbg_addr_i,
  input  logic [DATA_W-1:0] dbg_wdata_i,
  output logic              dbg_gnt_o,
  output logic              dbg_rvalid_o,
  output logic [DATA_W-1:0] dbg_rdata_o,

  output logic              mem_we_o,
  output logic [ADDR_W-1:0] mem_waddr_o,
  output logic [DATA_W-1:0] mem_wdata_o,
  output logic [ADDR_W-1:0] mem_raddr_o,
  input  logic [DATA_W-1:0] mem_rdata_i
);

  arb_state_e        state_q, state_d;
  logic              run_q;
  logic              cpu_gnt_q, dbg_gnt_q;
  logic              cpu_rvalid_q, dbg_rvalid_q;
  logic [DATA_W-1:0] cpu_rdata_q, dbg_rdata_q;

  logic              prio_dbg;
  logic              win_cpu, win_dbg;
  logic              cpu_rd, dbg_rd;

  dmem_arb_pick u_pick (
    .cpu_req_i  (cpu_req_i),
    .dbg_req_i  (dbg_req_i),
    .prio_dbg_i (prio_dbg),
    .win_cpu_o  (win_cpu),
    .win_dbg_o  (win_dbg)
  );

  // run_q holds arbitration off for the first edge after reset release.
  always_comb begin
    state_d = IDLE;
    if (run_q) begin
      if (win_cpu) begin
        state_d = GNT_CPU;
      end else if (win_dbg) begin
        state_d = GNT_DBG;
      end
    end
  end

`ifdef DMEM_ARB_ROUND_ROBIN_EN
  logic last_dbg_q;

  assign prio_dbg = ~last_dbg_q;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      last_dbg_q <= 1'b1;
    end else if (state_d == GNT_CPU) begin
      last_dbg_q <= 1'b0;
    end else if (state_d == GNT_DBG) begin
      last_dbg_q <= 1'b1;
    end
  end
`else
  localparam int CNT_W = (STARVE_MAX < 1) ? 1 : $clog2(STARVE_MAX + 1);
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(STARVE_MAX);

  logic [CNT_W-1:0] starve_q;

  assign prio_dbg = (starve_q == CNT_MAX);

  // Counts CPU wins decided while DBG is waiting; the DBG win that follows clears it.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      starve_q <= '0;
    end else if (!dbg_req_i || (state_d == GNT_DBG)) begin
      starve_q <= '0;
    end else if ((state_d == GNT_CPU) && (starve_q != CNT_MAX)) begin
      starve_q <= starve_q + 1'b1;
    end
  end
`endif

  assign cpu_rd = (state_q == GNT_CPU) && !cpu_we_i;
  assign dbg_rd = (state_q == GNT_DBG) && !dbg_we_i;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q      <= IDLE;
      run_q        <= 1'b0;
      cpu_gnt_q    <= 1'b0;
      dbg_gnt_q    <= 1'b0;
      cpu_rvalid_q <= 1'b0;
      dbg_rvalid_q <= 1'b0;
      cpu_rdata_q  <= '0;
      dbg_rdata_q  <= '0;
    end else begin
      run_q        <= 1'b1;
      state_q      <= state_d;
      cpu_gnt_q    <= (state_d == GNT_CPU);
      dbg_gnt_q    <= (state_d == GNT_DBG);
      cpu_rvalid_q <= cpu_rd;
      dbg_rvalid_q <= dbg_rd;
      if (cpu_rd) begin
        cpu_rdata_q <= mem_rdata_i;
      end
      if (dbg_rd) begin
        dbg_rdata_q <= mem_rdata_i;
      end
    end
  end

  // Decoded from state_q so an asynchronous reset drops mem_we at once.
  always_comb begin
    mem_we_o    = 1'b0;
    mem_waddr_o = '0;
    mem_wdata_o = '0;
    mem_raddr_o = '0;
    unique case (state_q)
      GNT_CPU: begin
        mem_we_o    = cpu_we_i;
        mem_waddr_o = cpu_addr_i;
        mem_raddr_o = cpu_addr_i;
        mem_wdata_o = cpu_wdata_i;
      end
      GNT_DBG: begin
        mem_we_o    = dbg_we_i;
        mem_waddr_o = dbg_addr_i;
        mem_raddr_o = dbg_addr_i;
        mem_wdata_o = dbg_wdata_i;
      end
      default: begin
        mem_we_o    = 1'b0;
        mem_waddr_o = '0;
        mem_wdata_o = '0;
        mem_raddr_o = '0;
      end
    endcase
  end

  assign cpu_gnt_o    = cpu_gnt_q;
  assign dbg_gnt_o    = dbg_gnt_q;
  assign cpu_rvalid_o = cpu_rvalid_q;
  assign dbg_rvalid_o = dbg_rvalid_q;
  assign cpu_rdata_o  = cpu_rdata_q;
  assign dbg_rdata_o  = dbg_rdata_q;

  a_one_gnt : assert property (@(posedge clk_i) disable iff (!rst_ni)
                               !(cpu_gnt_q && dbg_gnt_q));

endmodule : dmem_arbiter

`default_nettype wire

// File: tb/tb_dmem_arbiter.sv
// ============================================================================
// Module  : tb_dmem_arbiter
// Brief   : Directed self-checking bench for dmem_arbiter (either arbitration
//           mode, selected by DMEM_ARB_ROUND_ROBIN_EN).
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_dmem_arbiter;

  logic       clk;
  logic       rst_n;
  logic       cpu_req, cpu_we, dbg_req, dbg_we;
  logic [3:0] cpu_addr, dbg_addr;
  logic [7:0] cpu_wdata, dbg_wdata;
  logic       cpu_gnt, cpu_rvalid, dbg_gnt, dbg_rvalid;
  logic [7:0] cpu_rdata, dbg_rdata;
  logic       mem_we;
  logic [3:0] mem_waddr, mem_raddr;
  logic [7:0] mem_wdata, mem_rdata;

  logic [7:0] mem [16];
  int total = 0;
  int bad   = 0;

  dmem_arbiter #(.ADDR_W(4), .DATA_W(8), .STARVE_MAX(7)) dut (
    .clk_i        (clk),
    .rst_ni       (rst_n),
    .cpu_req_i    (cpu_req),
    .cpu_we_i     (cpu_we),
    .cpu_addr_i   (cpu_addr),
    .cpu_wdata_i  (cpu_wdata),
    .cpu_gnt_o    (cpu_gnt),
    .cpu_rvalid_o (cpu_rvalid),
    .cpu_rdata_o  (cpu_rdata),
    .dbg_req_i    (dbg_req),
    .dbg_we_i     (dbg_we),
    .dbg_addr_i   (dbg_addr),
    .dbg_wdata_i  (dbg_wdata),
    .dbg_gnt_o    (dbg_gnt),
    .dbg_rvalid_o (dbg_rvalid),
    .dbg_rdata_o  (dbg_rdata),
    .mem_we_o     (mem_we),
    .mem_waddr_o  (mem_waddr),
    .mem_wdata_o  (mem_wdata),
    .mem_raddr_o  (mem_raddr),
    .mem_rdata_i  (mem_rdata)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  always @(posedge clk) begin
    if (mem_we) mem[mem_waddr] <= mem_wdata;
  end
  assign mem_rdata = mem[mem_raddr];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp)
    else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    logic exp_cpu;
    for (int i = 0; i < 16; i++) mem[i] = 8'h00;
    rst_n = 1'b0;
    cpu_req = 0; cpu_we = 0; cpu_addr = 0; cpu_wdata = 0;
    dbg_req = 0; dbg_we = 0; dbg_addr = 0; dbg_wdata = 0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_cpu_gnt", cpu_gnt, 0);
    chk("rst_dbg_gnt", dbg_gnt, 0);
    chk("rst_cpu_rvalid", cpu_rvalid, 0);
    chk("rst_dbg_rvalid", dbg_rvalid, 0);
    chk("rst_cpu_rdata", cpu_rdata, 0);
    chk("rst_dbg_rdata", dbg_rdata, 0);
    chk("rst_mem_we", mem_we, 0);

    // release with a pending CPU write: first edge must not grant
    rst_n = 1'b1;
    cpu_req = 1; cpu_we = 1; cpu_addr = 4'd3; cpu_wdata = 8'hA5;
    step();
    chk("rel_edge1_gnt", cpu_gnt, 0);
    step();
    chk("rel_edge2_gnt", cpu_gnt, 1);
    chk("wr3_mem_we", mem_we, 1);
    chk("wr3_waddr", mem_waddr, 3);
    chk("wr3_wdata", mem_wdata, 8'hA5);
    chk("wr3_dbg_gnt", dbg_gnt, 0);
    cpu_req = 0;
    step();
    chk("wr3_after_gnt", cpu_gnt, 0);
    chk("wr3_no_rvalid", cpu_rvalid, 0);
    chk("idle_mem_we", mem_we, 0);
    chk("idle_waddr", mem_waddr, 0);

    // plain CPU write, one-cycle grant latency
    cpu_req = 1; cpu_we = 1; cpu_addr = 4'd5; cpu_wdata = 8'h3C;
    step();
    chk("wr5_gnt", cpu_gnt, 1);
    chk("wr5_waddr", mem_waddr, 5);
    cpu_req = 0;
    step();
    chk("wr5_no_rvalid", cpu_rvalid, 0);
    chk("wr5_rdata_keep", cpu_rdata, 0);

    // DBG read of addr 3
    dbg_req = 1; dbg_we = 0; dbg_addr = 4'd3;
    step();
    chk("rd3_dbg_gnt", dbg_gnt, 1);
    chk("rd3_cpu_gnt", cpu_gnt, 0);
    chk("rd3_raddr", mem_raddr, 3);
    chk("rd3_mem_we", mem_we, 0);
    dbg_req = 0;
    step();
    chk("rd3_rvalid", dbg_rvalid, 1);
    chk("rd3_rdata", dbg_rdata, 8'hA5);
    chk("rd3_cpu_rdata", cpu_rdata, 0);
    chk("rd3_gnt_drop", dbg_gnt, 0);
    step();
    chk("rd3_rvalid_pulse", dbg_rvalid, 0);
    chk("rd3_rdata_hold", dbg_rdata, 8'hA5);

    // CPU read of addr 5
    cpu_req = 1; cpu_we = 0; cpu_addr = 4'd5;
    step();
    chk("rd5_gnt", cpu_gnt, 1);
    cpu_req = 0;
    step();
    chk("rd5_rvalid", cpu_rvalid, 1);
    chk("rd5_rdata", cpu_rdata, 8'h3C);
    chk("rd5_dbg_rdata", dbg_rdata, 8'hA5);

    // DBG write must not touch dbg_rdata
    dbg_req = 1; dbg_we = 1; dbg_addr = 4'd3; dbg_wdata = 8'h77;
    step();
    chk("dwr_gnt", dbg_gnt, 1);
    chk("dwr_wdata", mem_wdata, 8'h77);
    dbg_req = 0;
    step();
    chk("dwr_no_rvalid", dbg_rvalid, 0);
    chk("dwr_rdata_keep", dbg_rdata, 8'hA5);

    // one-shot contention: CPU first, then DBG
    cpu_req = 1; cpu_we = 0; cpu_addr = 4'd5;
    dbg_req = 1; dbg_we = 0; dbg_addr = 4'd3;
    step();
    chk("both_cpu_first", cpu_gnt, 1);
    chk("both_dbg_wait", dbg_gnt, 0);
    cpu_req = 0;
    step();
    chk("both_dbg_next", dbg_gnt, 1);
    chk("both_cpu_off", cpu_gnt, 0);
    chk("both_cpu_rvalid", cpu_rvalid, 1);
    dbg_req = 0;
    step();
    chk("both_dbg_rvalid", dbg_rvalid, 1);
    chk("both_dbg_rdata", dbg_rdata, 8'h77);

    // continuous contention
    cpu_req = 1; cpu_we = 1; cpu_addr = 4'd1; cpu_wdata = 8'h11;
    dbg_req = 1; dbg_we = 0; dbg_addr = 4'd1;
    for (int i = 0; i < 24; i++) begin
      step();
`ifdef DMEM_ARB_ROUND_ROBIN_EN
      exp_cpu = ((i % 2) == 0);
`else
      exp_cpu = ((i % 8) != 7);
`endif
      chk($sformatf("cont_cpu_gnt[%0d]", i), cpu_gnt, exp_cpu);
      chk($sformatf("cont_dbg_gnt[%0d]", i), dbg_gnt, !exp_cpu);
    end
    cpu_req = 0; dbg_req = 0;
    step();
    chk("cont_end_cpu", cpu_gnt, 0);
    chk("cont_end_dbg", dbg_gnt, 0);

    // reset asserted in the middle of a CPU write grant
    cpu_req = 1; cpu_we = 1; cpu_addr = 4'd9; cpu_wdata = 8'h5A;
    step();
    chk("abort_pre_gnt", cpu_gnt, 1);
    chk("abort_pre_we", mem_we, 1);
    #2 rst_n = 1'b0;
    #1;
    chk("abort_mem_we", mem_we, 0);
    chk("abort_gnt", cpu_gnt, 0);
    chk("abort_cpu_rdata", cpu_rdata, 0);
    chk("abort_dbg_rdata", dbg_rdata, 0);
    step();
    chk("abort_hold_gnt", cpu_gnt, 0);
    rst_n = 1'b1;
    step();
    chk("abort_rel1_gnt", cpu_gnt, 0);
    chk("abort_rel1_rvalid", cpu_rvalid, 0);
    step();
    chk("abort_rel2_gnt", cpu_gnt, 1);
    chk("abort_rel2_we", mem_we, 1);
    cpu_req = 0;
    step();
    chk("abort_done", cpu_gnt, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule : tb_dmem_arbiter

`default_nettype wire
